if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and runs a request/acknowledge handshake with instruction memory. It drives the IF/ID register's load-enable and synchronous-clear inputs so that stalls hold the register, and branches or memory wait states insert NOPs. It absorbs memory latency and downstream stalls with a one-entry hold buffer.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/if_pc_reg.sv | 32 +++
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, datapath width and
// the constants used by the instruction-fetch stage.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;

    // All-zero word inserted into IF/ID as a bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    // Byte distance between consecutive instructions.
    localparam logic [INSTR_W-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register for the fetch stage.
// Priority: reset > redirect > increment > hold. Redirect targets are
// word-aligned by clearing the two low address bits.
module if_pc_reg #(
    parameter int unsigned          INSTR_W  = 32,
    parameter logic [INSTR_W-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_redirect,
    input  logic [INSTR_W-1:0] i_target,
    input  logic               i_incr,
    output logic [INSTR_W-1:0] o_pc
);
    import pipeline_pkg::*;

    logic [INSTR_W-1:0] r_pc;

    // Select the next PC: reset value, aligned redirect target, pc+4 or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_target & ~INSTR_W'(3);
        end else if (i_incr) begin
            r_pc <= r_pc + INSTR_W'(PC_INCR);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the request/acknowledge
// handshake with instruction memory and drives the IF/ID register's
// load-enable and clear. A one-entry buffer holds a word fetched while
// the pipeline is stalled; a stale in-flight request after a redirect is
// drained and discarded.
// Optional build macro IF_FETCH_STALL_CNT_EN adds the stall_cycles counter.
module if_fetch_unit #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               if_id_load_enable,
    output logic               if_id_clear,
    output logic [INSTR_W-1:0] pc_plus8
`ifdef IF_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    import pipeline_pkg::*;

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [INSTR_W-1:0] r_buffer;
    logic [INSTR_W-1:0] r_drain_addr;
    logic [INSTR_W-1:0] w_pc;
    logic               w_redirect;
    logic               w_incr;
    logic               w_buf_load;
    logic               w_buf_clear;
    logic               w_drain_load;

    if_pc_reg #(
        .INSTR_W  (INSTR_W),
        .RESET_PC (INSTR_W'(RESET_PC))
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .i_redirect (w_redirect),
        .i_target   (branch_target),
        .i_incr     (w_incr),
        .o_pc       (w_pc)
    );

    assign pc_plus8 = w_pc + INSTR_W'(2 * PC_INCR);

    // Next-state and IF/ID control; flush wins over stall, reset over all.
    always_comb begin
        w_state_nxt       = r_state;
        imem_req          = 1'b0;
        imem_addr         = w_pc;
        instruction       = NOP_INSTR;
        if_id_load_enable = 1'b1;
        if_id_clear       = 1'b1;
        w_redirect        = 1'b0;
        w_incr            = 1'b0;
        w_buf_load        = 1'b0;
        w_buf_clear       = 1'b0;
        w_drain_load      = 1'b0;
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (branch_taken) begin
                        w_redirect = 1'b1;
                        if (!imem_ack) begin
                            w_drain_load = 1'b1;
                            w_state_nxt  = DRAIN;
                        end
                    end else if (imem_ack && !stall) begin
                        if_id_clear = 1'b0;
                        instruction = imem_rdata;
                        w_incr      = 1'b1;
                    end else if (imem_ack) begin
                        if_id_load_enable = 1'b0;
                        if_id_clear       = 1'b0;
                        w_buf_load        = 1'b1;
                        w_state_nxt       = HOLD;
                    end else if (stall) begin
                        if_id_load_enable = 1'b0;
                        if_id_clear       = 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        w_redirect  = 1'b1;
                        w_buf_clear = 1'b1;
                        w_state_nxt = FETCH;
                    end else if (stall) begin
                        if_id_load_enable = 1'b0;
                        if_id_clear       = 1'b0;
                    end else begin
                        if_id_clear = 1'b0;
                        instruction = r_buffer;
                        w_incr      = 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
                DRAIN: begin
                    imem_req   = 1'b1;
                    imem_addr  = r_drain_addr;
                    w_redirect = branch_taken;
                    if (imem_ack) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    // State register, hold buffer and the address of the request being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_buffer     <= NOP_INSTR;
            r_drain_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_buf_load) begin
                r_buffer <= imem_rdata;
            end else if (w_buf_clear) begin
                r_buffer <= NOP_INSTR;
            end
            if (w_drain_load) begin
                r_drain_addr <= w_pc;
            end
        end
    end

`ifdef IF_FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // Count cycles lost to a downstream stall or an outstanding memory request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (stall || (imem_req && !imem_ack)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural fetch model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        if_id_load_enable;
    logic        if_id_clear;
    logic [31:0] pc_plus8;
`ifdef IF_FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc    = 32'h0;
    logic        m_hold  = 1'b0;
    logic [31:0] m_buf   = 32'h0;
    logic        m_drain = 1'b0;
    logic [31:0] m_daddr = 32'h0;
    logic [31:0] m_cnt   = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .INSTR_W  (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .instruction       (instruction),
        .if_id_load_enable (if_id_load_enable),
        .if_id_clear       (if_id_clear),
        .pc_plus8          (pc_plus8)
`ifdef IF_FETCH_STALL_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model at the edge.
    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [31:0] tgt, input logic ack);
        logic        e_req, e_le, e_clr;
        logic [31:0] e_addr, e_instr;
        reset = rst; stall = stl; branch_taken = br; branch_target = tgt; imem_ack = ack;
        #2;
        e_req = 1'b0; e_addr = 32'h0; e_le = 1'b1; e_clr = 1'b1; e_instr = 32'h0;
        if (!rst) begin
            if (m_drain) begin
                e_req = 1'b1; e_addr = m_daddr;
            end else if (m_hold) begin
                if (!br && stl) e_le = 1'b0;
                else if (!br) begin e_clr = 1'b0; e_instr = m_buf; end
            end else begin
                e_req = 1'b1; e_addr = m_pc;
                if (br) begin
                    e_le = 1'b1;
                end else if (ack && !stl) begin
                    e_clr = 1'b0; e_instr = mem_word(m_pc);
                end else if (stl) begin
                    e_le = 1'b0;
                end
            end
        end
        check_val("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check_val("imem_addr", imem_addr, e_addr);
        check_val("load_enable", 32'(if_id_load_enable), 32'(e_le));
        if (e_le) check_val("clear", 32'(if_id_clear), 32'(e_clr));
        if (e_le && !e_clr) check_val("instruction", instruction, e_instr);
        if (!rst) check_val("pc_plus8", pc_plus8, m_pc + 32'd8);
`ifdef IF_FETCH_STALL_CNT_EN
        if (!rst) check_val("stall_cycles", stall_cycles, m_cnt);
`endif
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_hold = 1'b0; m_buf = 32'h0;
            m_drain = 1'b0; m_daddr = 32'h0; m_cnt = 32'h0;
        end else begin
            if (stl || (e_req && !ack)) m_cnt = m_cnt + 32'd1;
            if (m_drain) begin
                if (br) m_pc = {tgt[31:2], 2'b00};
                if (ack) m_drain = 1'b0;
            end else if (br) begin
                if (!m_hold && !ack) begin
                    m_drain = 1'b1; m_daddr = m_pc;
                end
                m_hold = 1'b0;
                m_buf  = 32'h0;
                m_pc   = {tgt[31:2], 2'b00};
            end else if (m_hold) begin
                if (!stl) begin m_hold = 1'b0; m_pc = m_pc + 32'd4; end
            end else if (ack) begin
                if (stl) begin m_hold = 1'b1; m_buf = mem_word(m_pc); end
                else m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b0;
        @(posedge clk); #1;

        // Reset, then zero-wait fetches at 0,4,8,12
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
        // Two wait states at 0x10, then the word loads
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        check_val("pc_after_wait", pc_plus8, 32'h14 + 32'd8);
        // Ack under stall, held for three cycles, then released
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        check_val("addr_after_hold", imem_addr, 32'h18);
        // Redirect to 0x20, then to 0x100 while 0x20 is still pending
        step(0, 0, 1, 32'h20, 1);
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        check_val("addr_after_drain", imem_addr, 32'h100);
        // Branch while holding a buffered word under stall
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 1, 32'h200, 0);
        check_val("addr_after_hold_flush", imem_addr, 32'h200);
        step(0, 0, 0, 32'h0, 1);
        // Unaligned target at the top of memory, then wrap to zero
        step(0, 0, 1, 32'hFFFF_FFFF, 1);
        step(0, 0, 0, 32'h0, 1);
        check_val("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 0, 32'h0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
